imm_gen_stage: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage. Decodes every
//  RV32I immediate format (I, S, B, U, J) from a fetched instruction, sign-extends the

---
 rtl/imm_gen_pkg.sv | 39 +++
 rtl/imm_gen_stage_imm_decode.sv | 57 +++++
 rtl/imm_gen_stage.sv | 105 ++++++++++
 tb/tb_imm_gen_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the decode-stage immediate generator: format codes,
// RV32I major opcodes and the layout of a buffered entry.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam int FMT_W  = 3;
  localparam int META_W = FMT_W + 1;

  typedef struct packed {
    fmt_e fmt;
    logic illegal;
  } imm_meta_t;

  // Entry is packed as {imm, meta, target, pc}.
  function automatic int entry_width(input int xlen);
    return 3 * xlen + META_W;
  endfunction

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational immediate decoder: extracts the I/S/B/U/J immediate from an
// RV32I instruction word and sign-extends it to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        fmt   = FMT_I;
      end
      OP_STORE: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt   = FMT_S;
      end
      OP_BRANCH: begin
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {inst[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OP_JAL: begin
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OP_REG, OP_FENCE: begin
        imm32 = '0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // imm32[31] equals inst[31] for every format and stays 0 for NONE.
  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: decodes and sign-extends the immediate,
// forms the PC-relative target and buffers results behind a valid/ready skid stage.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  localparam int EW = entry_width(XLEN);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;
  logic            pc_rel;
  imm_meta_t       dec_meta;
  logic [EW-1:0]   in_entry;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign pc_rel     = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) || (in_inst[6:0] == OP_AUIPC);
  assign dec_target = pc_rel ? (in_pc + dec_imm) : '0;
  assign dec_meta   = '{fmt: dec_fmt, illegal: dec_illegal};
  assign in_entry   = {dec_imm, dec_meta, dec_target, in_pc};

  logic          out_valid_reg, out_valid_next;
  logic [EW-1:0] out_data_reg, out_data_next;
  logic          skid_valid_reg, skid_valid_next;
  logic [EW-1:0] skid_data_reg, skid_data_next;
  logic          accept;

  // With SKID=0 the skid entry never fills, so in_ready must see the consumer directly.
  assign in_ready = SKID ? ~skid_valid_reg : (out_ready | ~out_valid_reg);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      out_data_next   = '0;
      skid_valid_next = 1'b0;
      skid_data_next  = '0;
    end else if (!out_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        out_data_next   = skid_data_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_data_next  = in_entry;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (SKID && accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  imm_meta_t out_meta;

  assign {out_imm, out_meta, out_target, out_pc} = out_data_reg;
  assign out_fmt     = out_meta.fmt;
  assign out_illegal = out_meta.illegal;
  assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: table vectors, skid/flush/reset sequences
// and randomized traffic against a queue-based reference model.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Shared stimulus for the XLEN=32 instances (a: SKID=1, b: SKID=0)
  logic        flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        a_in_ready, a_out_valid, a_ill, b_in_ready, b_out_valid, b_ill;
  logic [31:0] a_imm, a_tgt, a_pc, b_imm, b_tgt, b_pc;
  logic [2:0]  a_fmt, b_fmt;

  // XLEN=64 instance
  logic        w_flush, w_in_valid, w_out_ready, w_in_ready, w_out_valid, w_ill;
  logic [31:0] w_in_inst;
  logic [63:0] w_in_pc, w_imm, w_tgt, w_pc;
  logic [2:0]  w_fmt;

  imm_gen_stage #(.XLEN(32), .SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill), .out_target(a_tgt), .out_pc(a_pc)
  );

  imm_gen_stage #(.XLEN(32), .SKID(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill), .out_target(b_tgt), .out_pc(b_pc)
  );

  imm_gen_stage #(.XLEN(64), .SKID(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_inst(w_in_inst), .in_pc(w_in_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_imm(w_imm), .out_fmt(w_fmt), .out_illegal(w_ill), .out_target(w_tgt), .out_pc(w_pc)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    bit          w64;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } vec_t;

  // Reference: immediate value built arithmetically from the instruction fields.
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [63:0] pc, input bit w64);
    exp_t   e;
    longint si;
    longint hi;
    logic [63:0] imm;
    bit     rel;
    si  = longint'($signed(inst));
    imm = 64'd0;
    rel = 1'b0;
    e.fmt = FMT_NONE;
    e.ill = 1'b0;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin hi = si >>> 20; imm = hi; e.fmt = FMT_I; end
      7'h23: begin hi = si >>> 25; imm = hi * 32 + 64'(inst[11:7]); e.fmt = FMT_S; end
      7'h63: begin
        hi = si >>> 31;
        imm = hi * 4096 + 64'(inst[7]) * 2048 + 64'(inst[30:25]) * 32 + 64'(inst[11:8]) * 2;
        e.fmt = FMT_B; rel = 1'b1;
      end
      7'h37: begin hi = si >>> 12; imm = hi * 4096; e.fmt = FMT_U; end
      7'h17: begin hi = si >>> 12; imm = hi * 4096; e.fmt = FMT_U; rel = 1'b1; end
      7'h6F: begin
        hi = si >>> 31;
        imm = hi * 1048576 + 64'(inst[19:12]) * 4096 + 64'(inst[20]) * 2048 + 64'(inst[30:21]) * 2;
        e.fmt = FMT_J; rel = 1'b1;
      end
      7'h33, 7'h0F: imm = 64'd0;
      default: e.ill = 1'b1;
    endcase
    e.tgt = rel ? pc + imm : 64'd0;
    if (!w64) begin
      imm   = {32'd0, imm[31:0]};
      e.tgt = {32'd0, e.tgt[31:0]};
    end
    e.imm = imm;
    e.pc  = pc;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F};
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 13);
    if (k < 12) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_a(input string nm, input exp_t e);
    chk({nm, " imm"}, 64'(a_imm), e.imm);
    chk({nm, " fmt"}, 64'(a_fmt), 64'(e.fmt));
    chk({nm, " illegal"}, 64'(a_ill), 64'(e.ill));
    chk({nm, " target"}, 64'(a_tgt), e.tgt);
    chk({nm, " pc"}, 64'(a_pc), e.pc);
  endtask

  task automatic cmp_b(input string nm, input exp_t e);
    chk({nm, " imm"}, 64'(b_imm), e.imm);
    chk({nm, " fmt"}, 64'(b_fmt), 64'(e.fmt));
    chk({nm, " illegal"}, 64'(b_ill), 64'(e.ill));
    chk({nm, " target"}, 64'(b_tgt), e.tgt);
    chk({nm, " pc"}, 64'(b_pc), e.pc);
  endtask

  task automatic cmp_w(input string nm, input exp_t e);
    chk({nm, " imm"}, w_imm, e.imm);
    chk({nm, " fmt"}, 64'(w_fmt), 64'(e.fmt));
    chk({nm, " illegal"}, 64'(w_ill), 64'(e.ill));
    chk({nm, " target"}, w_tgt, e.tgt);
    chk({nm, " pc"}, w_pc, e.pc);
  endtask

  task automatic apply32(input string nm, input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, " a valid"}, 64'(a_out_valid), 64'd1);
    cmp_a({nm, " a"}, e);
    chk({nm, " b valid"}, 64'(b_out_valid), 64'd1);
    cmp_b({nm, " b"}, e);
    $display("vec %s inst=%08h pc=%08h imm=%08h fmt=%0d tgt=%08h", nm, inst, pc, a_imm, a_fmt, a_tgt);
    @(posedge clk); #1;
  endtask

  task automatic apply64(input string nm, input logic [31:0] inst, input logic [63:0] pc, input exp_t e);
    w_in_valid = 1'b1; w_in_inst = inst; w_in_pc = pc; w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    chk({nm, " w valid"}, 64'(w_out_valid), 64'd1);
    cmp_w({nm, " w"}, e);
    $display("vec %s inst=%08h pc=%016h imm=%016h fmt=%0d tgt=%016h", nm, inst, pc, w_imm, w_fmt, w_tgt);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue models: out_valid whenever the queue holds something; capacity 2 with skid, 1 without.
  exp_t qa[$];
  exp_t qb[$];

  always @(negedge clk) begin
    bit mv, mr;
    if (mon_en) begin
      mv = (qa.size() != 0);
      mr = (qa.size() < 2);
      chk("rnd a out_valid", 64'(a_out_valid), 64'(mv));
      chk("rnd a in_ready", 64'(a_in_ready), 64'(mr));
      if (flush) qa.delete();
      else begin
        if (mv && out_ready) begin cmp_a("rnd a", qa[0]); void'(qa.pop_front()); end
        if (in_valid && mr) qa.push_back(ref_model(in_inst, {32'd0, in_pc}, 1'b0));
      end
    end
  end

  always @(negedge clk) begin
    bit mv, mr;
    if (mon_en) begin
      mv = (qb.size() != 0);
      mr = out_ready || (qb.size() == 0);
      chk("rnd b out_valid", 64'(b_out_valid), 64'(mv));
      chk("rnd b in_ready", 64'(b_in_ready), 64'(mr));
      if (flush) qb.delete();
      else begin
        if (mv && out_ready) begin cmp_b("rnd b", qb[0]); void'(qb.pop_front()); end
        if (in_valid && mr) qb.push_back(ref_model(in_inst, {32'd0, in_pc}, 1'b0));
      end
    end
  end

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    vec_t vecs [11];
    exp_t e;
    vecs[0]  = '{32'hFFF00093, 64'h0,        1'b0, 64'hFFFFFFFF, FMT_I,    1'b0, 64'h0};
    vecs[1]  = '{32'hFE112E23, 64'h0,        1'b0, 64'hFFFFFFFC, FMT_S,    1'b0, 64'h0};
    vecs[2]  = '{32'hFE000CE3, 64'h100,      1'b0, 64'hFFFFFFF8, FMT_B,    1'b0, 64'hF8};
    vecs[3]  = '{32'h001000EF, 64'h1000,     1'b0, 64'h800,      FMT_J,    1'b0, 64'h1800};
    vecs[4]  = '{32'h00001017, 64'h10,       1'b0, 64'h1000,     FMT_U,    1'b0, 64'h1010};
    vecs[5]  = '{32'h002081B3, 64'h20,       1'b0, 64'h0,        FMT_NONE, 1'b0, 64'h0};
    vecs[6]  = '{32'h0000007F, 64'h24,       1'b0, 64'h0,        FMT_NONE, 1'b1, 64'h0};
    vecs[7]  = '{32'h020000EF, 64'hFFFFFFF0, 1'b0, 64'h20,       FMT_J,    1'b0, 64'h10};
    vecs[8]  = '{32'hABCDE2B7, 64'h40,       1'b1, 64'hFFFFFFFFABCDE000, FMT_U, 1'b0, 64'h0};
    vecs[9]  = '{32'h0000007F, 64'h44,       1'b1, 64'h0,        FMT_NONE, 1'b1, 64'h0};
    vecs[10] = '{32'hFE000CE3, 64'h100,      1'b1, 64'hFFFFFFFFFFFFFFF8, FMT_B, 1'b0, 64'hF8};

    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_inst = '0; w_in_pc = '0;
    #12;
    chk("reset a out_valid", 64'(a_out_valid), 64'd0);
    chk("reset a in_ready", 64'(a_in_ready), 64'd1);
    chk("reset a imm", 64'(a_imm), 64'd0);
    chk("reset b in_ready", 64'(b_in_ready), 64'd1);
    chk("reset w out_valid", 64'(w_out_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      e.imm = vecs[i].imm; e.fmt = vecs[i].fmt; e.ill = vecs[i].ill;
      e.tgt = vecs[i].tgt; e.pc = vecs[i].pc;
      if (vecs[i].w64) apply64($sformatf("tbl%0d", i), vecs[i].inst, vecs[i].pc, e);
      else             apply32($sformatf("tbl%0d", i), vecs[i].inst, vecs[i].pc[31:0], e);
    end

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ri;
      logic [63:0] rp;
      ri = rand_inst();
      rp = {$urandom(), $urandom()};
      apply64($sformatf("r64_%0d", i), ri, rp, ref_model(ri, rp, 1'b1));
    end

    // Skid: A then B under backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_inst = NOP; in_pc = 32'h200;
    @(posedge clk); #1;
    chk("skid A valid", 64'(a_out_valid), 64'd1);
    chk("skid A pc", 64'(a_pc), 64'h200);
    chk("skid ready with out full", 64'(a_in_ready), 64'd1);
    in_pc = 32'h204;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("skid full in_ready", 64'(a_in_ready), 64'd0);
    chk("skid hold A", 64'(a_pc), 64'h200);
    @(posedge clk); #1;
    chk("skid stall hold A", 64'(a_pc), 64'h200);
    chk("skid stall in_ready", 64'(a_in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("skid B valid", 64'(a_out_valid), 64'd1);
    chk("skid B pc", 64'(a_pc), 64'h204);
    chk("skid in_ready back", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("skid drained", 64'(a_out_valid), 64'd0);
    $display("seq skid A/B done");
    idle(3);

    // No-skid: in_ready follows out_ready
    out_ready = 1'b0; in_valid = 1'b1; in_inst = NOP; in_pc = 32'h300;
    @(posedge clk); #1;
    chk("ns A pc", 64'(b_pc), 64'h300);
    chk("ns ready low", 64'(b_in_ready), 64'd0);
    in_pc = 32'h304;
    @(posedge clk); #1;
    chk("ns hold A", 64'(b_pc), 64'h300);
    out_ready = 1'b1; #1;
    chk("ns ready follows", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ns B valid", 64'(b_out_valid), 64'd1);
    chk("ns B pc", 64'(b_pc), 64'h304);
    @(posedge clk); #1;
    chk("ns drained", 64'(b_out_valid), 64'd0);
    $display("seq noskid A/B done");
    idle(3);

    // Flush with both entries full and a beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400;
    @(posedge clk); #1;
    in_pc = 32'h404;
    @(posedge clk); #1;
    chk("flush pre full", 64'(a_in_ready), 64'd0);
    flush = 1'b1; in_pc = 32'h408;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush a out_valid", 64'(a_out_valid), 64'd0);
    chk("flush a in_ready", 64'(a_in_ready), 64'd1);
    chk("flush b out_valid", 64'(b_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush beat dropped", 64'(a_out_valid), 64'd0);
    $display("seq flush done");
    idle(2);

    // Asynchronous reset in the middle of a transfer
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h001000EF; in_pc = 32'h500;
    w_out_ready = 1'b0; w_in_valid = 1'b1; w_in_inst = 32'h001000EF; w_in_pc = 64'h500;
    @(posedge clk); #1;
    chk("rst pre valid", 64'(a_out_valid), 64'd1);
    chk("rst pre target", 64'(a_tgt), 64'hD00);
    #2; rst_n = 1'b0; #1;
    chk("rst a out_valid", 64'(a_out_valid), 64'd0);
    chk("rst a imm", 64'(a_imm), 64'd0);
    chk("rst a fmt", 64'(a_fmt), 64'd0);
    chk("rst a target", 64'(a_tgt), 64'd0);
    chk("rst a pc", 64'(a_pc), 64'd0);
    chk("rst a in_ready", 64'(a_in_ready), 64'd1);
    chk("rst b out_valid", 64'(b_out_valid), 64'd0);
    chk("rst w out_valid", 64'(w_out_valid), 64'd0);
    chk("rst w imm", w_imm, 64'd0);
    in_valid = 1'b0; w_in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("seq async reset done");

    // Randomized traffic against the queue models
    mon_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_inst   = rand_inst();
      in_pc     = $urandom();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    $display("random phase done qa=%0d qb=%0d", qa.size(), qb.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
